// File: rtl/uio_arb_pkg.sv
// Shared types and constants for the uio bus arbiter.
package uio_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_TURN,
      ARB_OWN
   } arb_state_e;

   localparam logic [7:0] UIO_DRIVE_ALL  = 8'hFF;
   localparam logic [7:0] UIO_DRIVE_NONE = 8'h00;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester at or after rr, cyclically.
module rr_picker #(
   parameter int unsigned NREQ = 2
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] rr,
   output logic [NREQ-1:0]         pick,
   output logic                    valid
);

   always_comb begin
      int idx;
      pick = '0;
      idx  = 0;
      // Walk from the farthest offset back to rr so the nearest request wins.
      for (int k = int'(NREQ) - 1; k >= 0; k--) begin
         idx = (int'(rr) + k) % int'(NREQ);
         if (req[idx]) begin
            pick      = '0;
            pick[idx] = 1'b1;
         end
      end
   end

   assign valid = |req;

endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin arbiter sharing the uio pin bank, with turnaround on direction changes.
// Optional owner preemption after HOLD_MAX grant cycles: define UIO_ARB_PREEMPT_EN.
module uio_bus_arbiter
   import uio_arb_pkg::*;
#(
   parameter int unsigned NREQ     = 2,
   parameter int unsigned TURN_CYC = 1,
   parameter int unsigned HOLD_MAX = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   dir,
   input  logic [8*NREQ-1:0] wdata,
   input  logic [NREQ-1:0]   last,
   output logic [NREQ-1:0]   gnt,
   output logic [7:0]        rdata,
   output logic              rvalid,
   output logic              busy,
   output logic              preempt,
   input  logic [7:0]        uio_in,
   output logic [7:0]        uio_out,
   output logic [7:0]        uio_oe
);

   localparam int unsigned IdxW = $clog2(NREQ);

   arb_state_e      state_q, state_d;
   logic [IdxW-1:0] owner_q, owner_d;
   logic [IdxW-1:0] rr_q, rr_d, rr_next;
   logic            pdir_q, pdir_d;
   logic [1:0]      turn_q, turn_d;
   logic [7:0]      rdata_q, rdata_d;
   logic            rvalid_q, rvalid_d;
   logic            preempt_q, preempt_d;

   logic [NREQ-1:0] pick_oh;
   logic            pick_valid;
   logic [IdxW-1:0] pick_idx;
   logic [NREQ-1:0] owner_oh;
   logic            own;
   logic            drive;
   logic            release_now;
   logic            preempt_now;

   rr_picker #(
      .NREQ(NREQ)
   ) u_picker (
      .req  (req),
      .rr   (rr_q),
      .pick (pick_oh),
      .valid(pick_valid)
   );

   always_comb begin
      pick_idx = '0;
      owner_oh = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (pick_oh[i]) pick_idx = IdxW'(i);
         owner_oh[i] = (owner_q == IdxW'(i));
      end
   end

   assign own         = (state_q == ARB_OWN);
   // Owner direction is the latched pdir, so pad drive depends on flops only.
   assign drive       = own & pdir_q;
   assign release_now = own & (~req[owner_q] | last[owner_q]);
   assign rr_next     = (owner_q == IdxW'(NREQ - 1)) ? '0 : owner_q + IdxW'(1);

`ifdef UIO_ARB_PREEMPT_EN
   localparam int unsigned HoldW = $clog2(HOLD_MAX + 1);

   logic [HoldW-1:0] hold_q, hold_d;
   logic             hold_done;

   assign hold_done = (hold_q >= HoldW'(HOLD_MAX - 1));

   // Counts grant cycles of the current ownership, saturating at the limit.
   always_comb begin
      hold_d = '0;
      if (own) hold_d = hold_done ? hold_q : hold_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) hold_q <= '0;
      else        hold_q <= hold_d;
   end

   assign preempt_now = own & hold_done & (|(req & ~owner_oh)) & ~release_now;
`else
   logic unused_hold_max;
   assign unused_hold_max = (HOLD_MAX == 0);
   assign preempt_now     = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      rr_d      = rr_q;
      pdir_d    = pdir_q;
      turn_d    = turn_q;
      preempt_d = 1'b0;
      rvalid_d  = own & ~pdir_q & req[owner_q];
      rdata_d   = rvalid_d ? uio_in : rdata_q;
      case (state_q)
         ARB_IDLE: begin
            if (ena && pick_valid) begin
               owner_d = pick_idx;
               pdir_d  = dir[pick_idx];
               if (TURN_CYC > 0 && dir[pick_idx] != pdir_q) begin
                  state_d = ARB_TURN;
                  turn_d  = 2'(TURN_CYC - 1);
               end else begin
                  state_d = ARB_OWN;
               end
            end
         end
         ARB_TURN: begin
            if (turn_q == '0) state_d = ARB_OWN;
            else              turn_d  = turn_q - 1'b1;
         end
         ARB_OWN: begin
            if (release_now || preempt_now) begin
               state_d   = ARB_IDLE;
               rr_d      = rr_next;
               preempt_d = preempt_now;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ARB_IDLE;
         owner_q   <= '0;
         rr_q      <= '0;
         pdir_q    <= 1'b0;
         turn_q    <= '0;
         rdata_q   <= 8'h00;
         rvalid_q  <= 1'b0;
         preempt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         rr_q      <= rr_d;
         pdir_q    <= pdir_d;
         turn_q    <= turn_d;
         rdata_q   <= rdata_d;
         rvalid_q  <= rvalid_d;
         preempt_q <= preempt_d;
      end
   end

   assign gnt     = own ? owner_oh : '0;
   assign uio_oe  = drive ? UIO_DRIVE_ALL : UIO_DRIVE_NONE;
   assign uio_out = drive ? wdata[8*int'(owner_q) +: 8] : 8'h00;
   assign rdata   = rdata_q;
   assign rvalid  = rvalid_q;
   assign busy    = (state_q != ARB_IDLE);
   assign preempt = preempt_q;

endmodule
